// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bundle for the shared register arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface dff_bank_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [IdW-1:0]        gnt_id;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  timeout;

  modport master (
    output req, we, din,
    input  gnt, gnt_id, q, busy, timeout
  );

  modport slave (
    input  req, we, din,
    output gnt, gnt_id, q, busy, timeout
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register, with an
// optional hold limit that forces release after MAX_HOLD owned cycles.
module dff_bank_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  dff_bank_arbiter_if.slave io_bus
);
  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] HoldLast = (MAX_HOLD > 0) ? CntW'(MAX_HOLD - 1) : '0;
  localparam logic [IdW-1:0]  IdMax    = IdW'(NREQ - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IdW-1:0]   r_gnt_id;
  logic [IdW-1:0]   r_ptr;
  logic [CntW-1:0]  r_hold;
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_timeout;

  int               w_idx;
  logic [IdW-1:0]   w_cand;
  logic             w_found;
  logic [IdW-1:0]   w_win_id;
  logic [NREQ-1:0]  w_win_onehot;
  logic             w_own_req;
  logic             w_own_we;
  logic [WIDTH-1:0] w_own_din;
  logic             w_hold_expire;
  logic [IdW-1:0]   w_ptr_next;

  // First requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_idx    = 0;
    w_cand   = '0;
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= int'(NREQ)) w_idx = w_idx - int'(NREQ);
      w_cand = IdW'(w_idx);
      if (!w_found && io_bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_win_id = w_cand;
      end
    end
    w_win_onehot = NREQ'(1) << w_win_id;
  end

  // Current owner's request, write strobe, data slice and release bookkeeping.
  always_comb begin
    w_own_req     = io_bus.req[r_gnt_id];
    w_own_we      = io_bus.we[r_gnt_id];
    w_own_din     = io_bus.din[int'(r_gnt_id) * int'(WIDTH) +: WIDTH];
    w_hold_expire = (MAX_HOLD != 0) && (r_hold == HoldLast);
    w_ptr_next    = (r_gnt_id == IdMax) ? '0 : r_gnt_id + 1'b1;
  end

  // Grant FSM, hold counter and shared register; reset drops any in-flight write.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_q       <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_win_onehot;
            r_gnt_id <= w_win_id;
            r_busy   <= 1'b1;
            r_hold   <= '0;
            r_state  <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_own_we) r_q <= w_own_din;
          r_hold <= r_hold + 1'b1;
          if (!w_own_req || w_hold_expire) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= w_ptr_next;
            r_state   <= ST_IDLE;
            // Only a release with req still high is a forced one.
            r_timeout <= w_own_req;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.gnt     = r_gnt;
  assign io_bus.gnt_id  = r_gnt_id;
  assign io_bus.q       = r_q;
  assign io_bus.busy    = r_busy;
  assign io_bus.timeout = r_timeout;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: a behavioural owner/queue model is
// checked every cycle, and literal expectations pin the key scenarios.
module tb_dff_bank_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic n_rst;

  dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_bank_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) u_dut (
    .i_clk  (clk),
    .i_n_rst(n_rst),
    .io_bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [WIDTH-1:0] v);
    bus.din[i*WIDTH +: WIDTH] = v;
  endtask

  // Model: who owns the register (-1 = nobody), last owner, next search
  // start, owned edges so far, register contents, forced-release flag.
  int               m_owner = -1;
  int               m_last  = 0;
  int               m_ptr   = 0;
  int               m_held  = 0;
  int               m_c     = 0;
  logic [WIDTH-1:0] m_q     = '0;
  bit               m_to    = 1'b0;
  bit               m_valid = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_q     = '0;
      m_to    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_ptr + k) % NREQ;
          if (m_owner < 0 && bus.req[m_c]) begin
            m_owner = m_c;
            m_last  = m_c;
            m_held  = 0;
          end
        end
      end else begin
        if (bus.we[m_owner]) m_q = bus.din[m_owner*WIDTH +: WIDTH];
        m_held++;
        if (!bus.req[m_owner] || (MAX_HOLD > 0 && m_held == MAX_HOLD)) begin
          m_to    = bus.req[m_owner];
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("m_gnt_id", 32'(bus.gnt_id), 32'(m_last));
      check("m_q", 32'(bus.q), 32'(m_q));
      check("m_busy", 32'(bus.busy), 32'(m_owner >= 0));
      check("m_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected finish");
    $fatal(1);
  end

  int               order[5]   = '{0, 1, 2, 3, 0};
  logic [WIDTH-1:0] t4_vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    // 1: reset with everything asserted, then first grant.
    n_rst   = 1'b0;
    bus.req = 4'b1111;
    bus.we  = 4'b1111;
    bus.din = {4{8'hC3}};
    cyc();
    cyc();
    check("t1_gnt", 32'(bus.gnt), 32'h0);
    check("t1_q", 32'(bus.q), 32'h00);
    check("t1_busy", 32'(bus.busy), 32'h0);
    check("t1_timeout", 32'(bus.timeout), 32'h0);
    n_rst = 1'b1;
    cyc();
    check("t1_first_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    bus.we  = 4'b0000;
    cyc();

    // 2: single owner write; a non-owner's we is ignored.
    bus.req = 4'b0100;
    cyc();
    check("t2_gnt", 32'(bus.gnt), 32'b0100);
    check("t2_gnt_id", 32'(bus.gnt_id), 32'd2);
    bus.we = 4'b0101;
    set_din(2, 8'hA5);
    set_din(0, 8'hFF);
    cyc();
    check("t2_q", 32'(bus.q), 32'hA5);
    bus.we  = 4'b0000;
    bus.req = 4'b0000;
    cyc();
    check("t2_rel_gnt", 32'(bus.gnt), 32'h0);
    check("t2_hold_id", 32'(bus.gnt_id), 32'd2);

    // 3: rotation from a fresh pointer.
    n_rst = 1'b0;
    cyc();
    check("t3_rst_q", 32'(bus.q), 32'h00);
    n_rst = 1'b1;
    cyc();
    bus.req = 4'b1111;
    cyc();
    for (int g = 0; g < 5; g++) begin
      check($sformatf("t3_gnt_id%0d", g), 32'(bus.gnt_id), 32'(order[g]));
      check($sformatf("t3_gnt%0d", g), 32'(bus.gnt), 32'd1 << order[g]);
      cyc();
      bus.req[order[g]] = 1'b0;
      cyc();
      check($sformatf("t3_gap%0d", g), 32'(bus.gnt), 32'h0);
      if (g < 4) begin
        bus.req[order[g]] = 1'b1;
        cyc();
      end
    end

    // 4: hold limit forces release after four owned writes.
    bus.req = 4'b0011;
    cyc();
    check("t4_gnt", 32'(bus.gnt), 32'b0010);
    bus.we = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      set_din(1, t4_vals[i]);
      cyc();
      if (i < 3) begin
        check($sformatf("t4_own%0d", i), 32'(bus.gnt), 32'b0010);
        check($sformatf("t4_noto%0d", i), 32'(bus.timeout), 32'h0);
      end
    end
    check("t4_q", 32'(bus.q), 32'h44);
    check("t4_timeout", 32'(bus.timeout), 32'h1);
    check("t4_rel_gnt", 32'(bus.gnt), 32'h0);
    bus.we = 4'b0000;
    cyc();
    check("t4_next_gnt", 32'(bus.gnt), 32'b0001);
    check("t4_to_clear", 32'(bus.timeout), 32'h0);

    // 5: owner 3 drops req as requester 0 raises it.
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b1000;
    cyc();
    check("t5_gnt3", 32'(bus.gnt), 32'b1000);
    cyc();
    bus.req = 4'b0011;
    cyc();
    check("t5_gap", 32'(bus.gnt), 32'h0);
    check("t5_gap_id", 32'(bus.gnt_id), 32'd3);
    cyc();
    check("t5_wrap_gnt", 32'(bus.gnt), 32'b0001);

    // 6: reset lands on the same edge as an owner's write.
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b0100;
    cyc();
    check("t6_gnt", 32'(bus.gnt), 32'b0100);
    bus.we = 4'b0100;
    set_din(2, 8'h5A);
    n_rst = 1'b0;
    cyc();
    check("t6_q", 32'(bus.q), 32'h00);
    check("t6_gnt_rst", 32'(bus.gnt), 32'h0);
    check("t6_busy", 32'(bus.busy), 32'h0);
    n_rst   = 1'b1;
    bus.we  = 4'b0000;
    bus.req = 4'b0110;
    cyc();
    check("t6_regnt", 32'(bus.gnt), 32'b0010);
    check("t6_regnt_id", 32'(bus.gnt_id), 32'd1);
    bus.req = 4'b0000;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer that shares one WIDTH-bit D flip-flop register among NREQ requesters.
- Each requester raises req, owns the register once granted, and writes it through we/din while it holds the grant.
- A hold limit bounds how long one requester can own the register.
- Sits between the requester blocks and the shared storage flop bank; q is the bank's registered output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.
- MAX_HOLD, 4, maximum owned cycles per grant; 0 = unlimited.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- n_rst  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester ownership request; bit i = requester i.
- we  input  NREQ  per-requester write enable; honoured only for the granted requester.
- din  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; all zero when idle.
- gnt_id  output  clog2(NREQ)  index of current or last owner.
- q  output  WIDTH  shared register value.
- busy  output  1  high while in OWN.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset: sampled only on a clk edge with n_rst=0. On that edge: gnt=0, gnt_id=0, q=0, busy=0, timeout=0, round-robin pointer ptr=0, hold counter=0, state=IDLE.
- Reset has priority over everything, including an in-flight write, which is dropped.
- States: IDLE and OWN.
- IDLE transitions:
  - No req bit set: stay in IDLE, outputs hold.
  - Any req bit set: pick the first set bit searching ptr, ptr+1, … mod NREQ as winner w.
  - On that edge: gnt=one-hot(w), gnt_id=w, busy=1, hold counter=0, state=OWN.
  - Grant latency: req sampled at edge k gives gnt visible after edge k.
- OWN write:
  - On each edge with gnt[w]=1 and we[w]=1, q <= din slice w.
  - q changes on the same edge that samples we.
  - we from non-granted requesters is ignored.
  - In IDLE, all we bits are ignored.
- OWN release:
  - req[w]=0 at an edge gives normal release: gnt=0, busy=0, ptr=(w+1) mod NREQ, state=IDLE.
  - A write is still honoured on the release edge if we[w]=1.
- OWN timeout (MAX_HOLD>0):
  - The hold counter increments on every owned edge.
  - If req[w]=1 on the edge where counter = MAX_HOLD-1, force release: same actions as normal release, plus timeout=1 for exactly one cycle.
  - The write on that edge is still honoured.
  - Owned cycles per grant are therefore at most MAX_HOLD.
- Release-to-grant gap: every release passes through IDLE for at least one cycle with gnt=0. There is no back-to-back grant.
- Fairness: after any release, the previous owner has lowest priority in the next arbitration. A requester that re-asserts or keeps req high after a timeout re-enters arbitration normally.
- gnt_id holds the last owner while in IDLE.
- Widths:
  - The hold counter is clog2(MAX_HOLD+1) bits, minimum 1.
  - ptr wraps modulo NREQ; NREQ need not be a power of two.
- Invariants: gnt is always zero or one-hot. busy == |gnt.

Test Plan:
1. Reset and idle: hold n_rst=0 for 2 edges with req=4'b1111 and we=4'b1111 → gnt=0, q=8'h00, busy=0, timeout=0. Release reset → gnt=4'b0001 one edge later.
2. Single-owner write: req=4'b0100, then we[2]=1 with din slice 2=8'hA5 for one edge → gnt=4'b0100, gnt_id=2, q=8'hA5 after that edge. we[0]=1 with 8'hFF at the same time has no effect.
3. Round-robin rotation: req=4'b1111 held constant, each owner drops req after 2 cycles and re-raises it one cycle later → grant order 0,1,2,3,0, with one gnt=0 cycle between each grant.
4. Timeout: MAX_HOLD=4, req[1] held high, we[1]=1 writing 8'h11,8'h22,8'h33,8'h44 on successive edges → 4 owned cycles, q=8'h44, timeout pulses once, gnt drops. With req=4'b0011, the next grant goes to requester 0 only if the search from ptr=2 finds it first (it does: 2,3,0).
5. Release/request collision: owner 3 drops req on the same edge requester 0 raises req → one IDLE cycle, then gnt=4'b0001 with ptr wrap 3→0.
6. Mid-ownership reset: while owner 2 is writing 8'h5A, assert n_rst=0 on that edge → q=8'h00, gnt=0, ptr=0. After reset with req=4'b0110, the grant goes to requester 1.
